grid_loader: RTL and testbench
==============================

Name: grid_loader

Overview:
- Builds the 9x9 candidate-mask grid that the scanning stage consumes, in two ways:
  - Puzzle load: accepts a serial stream of 81 decimal digits over a valid/ready handshake and converts each digit to a 9-bit candidate mask.
  - Writeback: re-assembles the box-major result grid from the scanning stage back into row/column order.
- Holds the grid in registers and drives it continuously to the solver.

Parameters:
- N_CELLS, 81, cells per puzzle. Fixed; kept for readability only.
- MASK_ALL, 9'h1FF, mask loaded for an empty cell (digit 0).

Ports:
- i_Clk  input  1  system clock, rising edge.
- i_Rst_n  input  1  asynchronous active-low reset.
- i_Start  input  1  one-cycle pulse; begins a new puzzle load.
- i_Digit  input  4  cell digit: 0 = empty, 1..9 = given.
- i_Valid  input  1  i_Digit is valid this cycle.
- o_Ready  output  1  loader accepts a digit this cycle.
- i_Wb_Valid  input  1  one-cycle pulse; capture i_Wb_Grid.
- i_Wb_Grid  input  3x3x9x9  box-major grid, indexed [bi][bj][n] of 9-bit masks.
- o_Grid  output  9x9x9  row/column grid, indexed [col][row] of 9-bit masks.
- o_Count  output  7  digits accepted in the current load (0..81).
- o_Loaded  output  1  one-cycle pulse when the 81st digit is accepted.
- o_Busy  output  1  high in LOAD state.
- o_Error  output  1  sticky; set on an illegal digit. Cleared by i_Start or reset.

Behaviour:
- Reset (async, i_Rst_n low):
  - State = IDLE.
  - Every o_Grid cell = 0.
  - o_Count = 0; col = 0; row = 0.
  - o_Ready, o_Loaded, o_Busy and o_Error all = 0.
- Reset mid-load discards the partial grid; no o_Loaded pulse is produced.
- States: IDLE, LOAD, HOLD, ERR.
  - IDLE: o_Ready = 0.
    - i_Start -> LOAD. Clears o_Count, col, row and o_Error. Grid contents are retained until overwritten.
  - LOAD: o_Ready = 1, o_Busy = 1. A digit is accepted when i_Valid && o_Ready.
    - Mask for the accepted digit: 0 -> MASK_ALL; d in 1..9 -> 9'b1 << (d-1).
    - The mask is written to o_Grid[col][row]; o_Count increments.
    - Column and row advance: col increments; on col == 8, col wraps to 0 and row increments.
    - Stream order is row-major: digit k lands at col = k mod 9, row = k / 9.
    - Use separate col/row counters; no division.
    - On the 81st accepted digit (o_Count 80 -> 81): pulse o_Loaded on the following cycle, go to HOLD, and o_Ready drops the same cycle.
    - Illegal digit (10..15) while accepted: no grid write, o_Error <= 1, go to ERR.
    - i_Start in LOAD restarts the load: counters clear and the cell at 0,0 is the next write.
  - HOLD: grid is valid and stable; o_Ready = 0.
    - i_Wb_Valid: on that edge, every o_Grid[3*bi+dx][3*bj+dy] <= i_Wb_Grid[bi][bj][dy*3+dx], for bi, bj, dx, dy in 0..2.
    - Writeback is atomic: all 81 cells update in one cycle. The new grid is visible on o_Grid the next cycle.
    - i_Start -> LOAD.
  - ERR: o_Ready = 0; grid frozen; o_Error stays 1.
    - i_Start -> LOAD and clears o_Error.
- i_Wb_Valid outside HOLD is ignored.
- i_Start together with i_Wb_Valid in HOLD: i_Start wins; the writeback is dropped.
- i_Valid while o_Ready = 0 is ignored. The source must hold i_Digit stable until accepted.
- Latency:
  - Accepted digit -> visible on o_Grid: 1 cycle.
  - Writeback -> visible on o_Grid: 1 cycle.
- o_Loaded is exactly one cycle wide and is not re-asserted while in HOLD.

Test Plan:
- Reset then i_Start, then 81 digits: 5,3,0,0,7,0,… (row-major). Required response:
  - o_Grid[0][0] = 9'h010, o_Grid[1][0] = 9'h004, o_Grid[2][0] = 9'h1FF.
  - o_Count = 81, one o_Loaded pulse, state HOLD, o_Ready = 0.
- Handshake gaps: i_Valid toggled 1,0,1 with o_Ready = 1. Only the two valid digits are accepted; o_Count = 2; col = 2.
- Digit 12 at k = 40: o_Error = 1, o_Grid[4][4] unchanged, o_Ready = 0. Then i_Start: o_Error = 0, o_Count = 0.
- In HOLD, i_Wb_Valid with i_Wb_Grid[1][2][5] = 9'h080:
  - The next cycle o_Grid[5][7] = 9'h080 (dx = 2, dy = 1).
  - All other cells equal their corresponding box entries.
- In HOLD, i_Start and i_Wb_Valid in the same cycle: o_Grid unchanged, state LOAD, o_Count = 0.
- Assert i_Rst_n low after 30 digits: asynchronously, all of o_Grid = 0, o_Count = 0, o_Busy = 0; no o_Loaded pulse.

Source files
------------

// File: rtl/grid_loader.sv
// grid_loader: builds the 9x9 candidate-mask grid for the solver.
// A serial row-major stream of 81 digits is converted into one-hot masks
// (an empty cell becomes "all candidates"). Once loaded, the grid can be
// overwritten in one cycle by a box-major result grid.
module grid_loader #(
    parameter int         N_CELLS  = 81,
    parameter logic [8:0] MASK_ALL = 9'h1FF
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst_n,
    input  logic                         i_Start,
    input  logic [3:0]                   i_Digit,
    input  logic                         i_Valid,
    output logic                         o_Ready,
    input  logic                         i_Wb_Valid,
    input  logic [2:0][2:0][8:0][8:0]    i_Wb_Grid,
    output logic [8:0][8:0][8:0]         o_Grid,
    output logic [6:0]                   o_Count,
    output logic                         o_Loaded,
    output logic                         o_Busy,
    output logic                         o_Error
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    // Digit to candidate mask; 0 means any candidate is possible.
    function automatic logic [8:0] digit_to_mask(input logic [3:0] d);
        logic [8:0] m;
        case (d)
            4'd0:    m = MASK_ALL;
            4'd1:    m = 9'h001;
            4'd2:    m = 9'h002;
            4'd3:    m = 9'h004;
            4'd4:    m = 9'h008;
            4'd5:    m = 9'h010;
            4'd6:    m = 9'h020;
            4'd7:    m = 9'h040;
            4'd8:    m = 9'h080;
            4'd9:    m = 9'h100;
            default: m = 9'h000;
        endcase
        return m;
    endfunction

    logic [1:0]               state_q,  state_d;
    logic [6:0]               count_q,  count_d;
    logic [3:0]               col_q,    col_d;
    logic [3:0]               row_q,    row_d;
    logic [8:0][8:0][8:0]     grid_q,   grid_d;
    logic                     error_q,  error_d;
    logic                     loaded_q, loaded_d;
    logic                     ready_q;
    logic                     busy_q;
    logic [8:0][8:0][8:0]     wb_grid_s;
    logic                     accept_s;
    logic                     legal_s;

    // Box-major to column/row reordering is pure wiring with constant indices.
    for (genvar bi = 0; bi < 3; bi++) begin : g_bi
        for (genvar bj = 0; bj < 3; bj++) begin : g_bj
            for (genvar dx = 0; dx < 3; dx++) begin : g_dx
                for (genvar dy = 0; dy < 3; dy++) begin : g_dy
                    assign wb_grid_s[3*bi+dx][3*bj+dy] = i_Wb_Grid[bi][bj][dy*3+dx];
                end
            end
        end
    end

    assign accept_s = (state_q == S_LOAD) && i_Valid && ready_q;
    assign legal_s  = (i_Digit <= 4'd9);

    // Next-state logic: start/restart, digit acceptance and writeback.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        col_d    = col_q;
        row_d    = row_q;
        grid_d   = grid_q;
        error_d  = error_q;
        loaded_d = 1'b0;
        if (i_Start) begin
            // Start wins over any digit or writeback in the same cycle.
            state_d = S_LOAD;
            count_d = 7'd0;
            col_d   = 4'd0;
            row_d   = 4'd0;
            error_d = 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (accept_s && legal_s) begin
                        grid_d[col_q][row_q] = digit_to_mask(i_Digit);
                        count_d = count_q + 7'd1;
                        if (col_q == 4'd8) begin
                            col_d = 4'd0;
                            row_d = row_q + 4'd1;
                        end else begin
                            col_d = col_q + 4'd1;
                        end
                        if (count_q == 7'(N_CELLS - 1)) begin
                            state_d  = S_HOLD;
                            loaded_d = 1'b1;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end else if (accept_s) begin
                        // Illegal digit: freeze the grid until the next start.
                        error_d = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
                S_HOLD: begin
                    if (i_Wb_Valid) begin
                        grid_d = wb_grid_s;
                    end else begin
                        grid_d = grid_q;
                    end
                end
                S_IDLE:  state_d = S_IDLE;
                S_ERR:   state_d = S_ERR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, counters, grid and registered status outputs.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= 7'd0;
            col_q    <= 4'd0;
            row_q    <= 4'd0;
            grid_q   <= '0;
            error_q  <= 1'b0;
            loaded_q <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            col_q    <= col_d;
            row_q    <= row_d;
            grid_q   <= grid_d;
            error_q  <= error_d;
            loaded_q <= loaded_d;
            ready_q  <= (state_d == S_LOAD);
            busy_q   <= (state_d == S_LOAD);
        end
    end

    assign o_Ready  = ready_q;
    assign o_Busy   = busy_q;
    assign o_Grid   = grid_q;
    assign o_Count  = count_q;
    assign o_Loaded = loaded_q;
    assign o_Error  = error_q;

endmodule

// File: tb/tb_grid_loader.sv
// Testbench for grid_loader: random digit streams and writeback grids
// checked against a cell-level reference model of the loader.
module tb_grid_loader;

    logic                      clk;
    logic                      rst_n;
    logic                      start;
    logic [3:0]                digit;
    logic                      valid;
    logic                      ready;
    logic                      wb_valid;
    logic [2:0][2:0][8:0][8:0] wb;
    logic [8:0][8:0][8:0]      grid;
    logic [6:0]                count;
    logic                      loaded;
    logic                      busy;
    logic                      error;

    grid_loader dut (
        .i_Clk      (clk),
        .i_Rst_n    (rst_n),
        .i_Start    (start),
        .i_Digit    (digit),
        .i_Valid    (valid),
        .o_Ready    (ready),
        .i_Wb_Valid (wb_valid),
        .i_Wb_Grid  (wb),
        .o_Grid     (grid),
        .o_Count    (count),
        .o_Loaded   (loaded),
        .o_Busy     (busy),
        .o_Error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected cells, load position and mode
    // (0 idle, 1 loading, 2 holding, 3 error).
    logic [8:0] exp_g [9][9];
    int m_count;
    int m_mode;
    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int n_loaded = 0;

    // Count o_Loaded pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (loaded === 1'b1) n_loaded <= n_loaded + 1;
    end

    function automatic logic [8:0] mk(input int d);
        if (d == 0) return 9'h1FF;
        return 9'(1 << (d - 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_grid(input string tag);
        for (int c = 0; c < 9; c++)
            for (int r = 0; r < 9; r++)
                chk($sformatf("%s[%0d][%0d]", tag, c, r), 32'(grid[c][r]), 32'(exp_g[c][r]));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_mode  = 1;
        m_count = 0;
    endtask

    // Present one digit for one cycle; the model takes it only when loading.
    task automatic drive(input int d, input logic v);
        logic take;
        take  = v && (m_mode == 1);
        valid = v;
        digit = 4'(d);
        tick();
        valid = 1'b0;
        if (take) begin
            if (d > 9) begin
                m_mode = 3;
            end else begin
                exp_g[m_count % 9][m_count / 9] = mk(d);
                m_count++;
                if (m_count == 81) m_mode = 2;
            end
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 9; c++)
            for (int r = 0; r < 9; r++)
                exp_g[c][r] = 9'h000;
        m_count = 0;
        m_mode  = 0;
    endtask

    task automatic random_wb();
        for (int bi = 0; bi < 3; bi++)
            for (int bj = 0; bj < 3; bj++)
                for (int n = 0; n < 9; n++)
                    wb[bi][bj][n] = 9'($urandom);
    endtask

    int first_row [9] = '{5, 3, 0, 0, 7, 0, 0, 0, 0};
    int d;
    int snap;

    initial begin
        rst_n = 1'b0; start = 1'b0; digit = 4'd0; valid = 1'b0;
        wb_valid = 1'b0; wb = '0;
        model_reset();
        #12;
        // Reset state.
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        check_grid("rst_grid");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_ready", 32'(ready), 32'd0);

        // Load 1: full puzzle with random handshake gaps.
        pulse_start();
        chk("load_ready", 32'(ready), 32'd1);
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_count0", 32'(count), 32'd0);
        for (int k = 0; k < 81; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                drive(int'($urandom_range(0, 9)), 1'b0);
                chk("gap_count", 32'(count), 32'(m_count));
            end
            d = (k < 9) ? first_row[k] : int'($urandom_range(0, 9));
            drive(d, 1'b1);
            chk("load_cell", 32'(grid[k % 9][k / 9]), 32'(mk(d)));
            if (k < 80) chk("load_count", 32'(count), 32'(k + 1));
        end
        chk("done_loaded", 32'(loaded), 32'd1);
        chk("done_ready", 32'(ready), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_count", 32'(count), 32'd81);
        chk("g00", 32'(grid[0][0]), 32'h010);
        chk("g10", 32'(grid[1][0]), 32'h004);
        chk("g20", 32'(grid[2][0]), 32'h1FF);
        check_grid("load1");
        tick();
        chk("loaded_width", 32'(loaded), 32'd0);
        drive(3, 1'b1);
        chk("hold_count", 32'(count), 32'd81);
        check_grid("hold_ignore");
        chk("loaded_pulses", 32'(n_loaded), 32'd1);

        // Writeback in HOLD: box-major entry n = dy*3+dx lands at col 3bi+dx, row 3bj+dy.
        random_wb();
        wb[1][2][5] = 9'h080;
        wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        for (int c = 0; c < 9; c++)
            for (int r = 0; r < 9; r++)
                exp_g[c][r] = wb[c / 3][r / 3][(r % 3) * 3 + (c % 3)];
        chk("wb_57", 32'(grid[5][7]), 32'h080);
        check_grid("wb");

        // Start and writeback together: start wins.
        random_wb();
        wb_valid = 1'b1;
        pulse_start();
        wb_valid = 1'b0;
        chk("sw_ready", 32'(ready), 32'd1);
        chk("sw_count", 32'(count), 32'd0);
        check_grid("sw_grid");

        // Load 2: explicit 1,0,1 gap, writeback ignored while loading, illegal digit at k=40.
        drive(4, 1'b1);
        drive(9, 1'b0);
        drive(6, 1'b1);
        chk("gap2_count", 32'(count), 32'd2);
        random_wb();
        wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        check_grid("wb_in_load");
        for (int k = 2; k < 40; k++) drive(int'($urandom_range(0, 9)), 1'b1);
        chk("col2_cell", 32'(grid[2][0]), 32'(exp_g[2][0]));
        drive(12, 1'b1);
        chk("err_error", 32'(error), 32'd1);
        chk("err_ready", 32'(ready), 32'd0);
        chk("err_count", 32'(count), 32'd40);
        chk("err_g44", 32'(grid[4][4]), 32'(exp_g[4][4]));
        drive(5, 1'b1);
        wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        chk("err_sticky", 32'(error), 32'd1);
        check_grid("err_frozen");
        pulse_start();
        chk("errclr_error", 32'(error), 32'd0);
        chk("errclr_count", 32'(count), 32'd0);
        chk("errclr_ready", 32'(ready), 32'd1);

        // Load 3: restart mid-load, then async reset after 30 digits.
        for (int k = 0; k < 5; k++) drive(int'($urandom_range(0, 9)), 1'b1);
        pulse_start();
        d = int'($urandom_range(1, 9));
        drive(d, 1'b1);
        chk("restart_g00", 32'(grid[0][0]), 32'(mk(d)));
        chk("restart_count", 32'(count), 32'd1);
        for (int k = 1; k < 30; k++) drive(int'($urandom_range(0, 9)), 1'b1);
        chk("pre_rst_count", 32'(count), 32'd30);
        snap = n_loaded;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(ready), 32'd0);
        chk("arst_loaded", 32'(loaded), 32'd0);
        check_grid("arst_grid");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_pulses", 32'(n_loaded), 32'(snap));
        chk("post_rst_ready", 32'(ready), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
